ucsbece154a_imem_arbiter: RTL and testbench

Two-port arbiter that shares the single read port of the instruction memory between the core's fetch path and a debug/trace read path. Each requester issues word reads with a request/grant handshake. The arbiter drives the memory address, registers the returned word, and answers with a one-cycle valid pulse. Addresses that are out of range or misaligned are flagged rather than silently aliased. It sits between the fetch stage / debug unit and the instruction memory.

---
 rtl/ucsbece154a_imem_arbiter.sv | 119 +++++++++++
 tb/tb_ucsbece154a_imem_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ucsbece154a_imem_arbiter.sv
// ucsbece154a_imem_arbiter
//   Shares the instruction memory read port between the fetch path (f_*)
//   and the debug/trace path (d_*). Round-robin on conflict using a
//   last-served pointer. Responses are registered per port with a
//   one-cycle rvalid pulse. Misaligned and out-of-range addresses are
//   flagged through err.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   f_req_i / f_addr_i      fetch request and byte address
//   f_gnt_o                 fetch accepted this cycle (combinational)
//   f_rvalid_o / f_rdata_o / f_err_o   fetch response (registered)
//   d_*                     same set for the debug port
//   mem_a_o                 word-aligned address to instruction memory
//   mem_rd_i                combinational read data from instruction memory
module ucsbece154a_imem_arbiter #(
    parameter int unsigned NUM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        f_req_i,
    input  logic [31:0] f_addr_i,
    output logic        f_gnt_o,
    output logic        f_rvalid_o,
    output logic [31:0] f_rdata_o,
    output logic        f_err_o,

    input  logic        d_req_i,
    input  logic [31:0] d_addr_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,
    output logic        d_err_o,

    output logic [31:0] mem_a_o,
    input  logic [31:0] mem_rd_i
);

    localparam int unsigned ADDR_WIDTH = $clog2(NUM_WORDS);

    typedef enum logic {
        LAST_F = 1'b0,
        LAST_D = 1'b1
    } last_e;

    last_e       last_q, last_d;
    logic [31:0] sel_addr;
    logic        misaligned;
    logic        out_of_range;
    logic [31:0] resp_data;
    logic        resp_err;

    // State register: reset to LAST_D so fetch wins the first conflict.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= LAST_D;
        end else begin
            last_q <= last_d;
        end
    end

    // Next-state: pointer follows the served port, holds when idle.
    always_comb begin
        last_d = last_q;
        if (f_gnt_o) begin
            last_d = LAST_F;
        end else if (d_gnt_o) begin
            last_d = LAST_D;
        end
    end

    // Outputs: grants and memory address. On conflict the port not served
    // last gets the grant.
    always_comb begin
        f_gnt_o  = f_req_i & (~d_req_i | (last_q == LAST_D));
        d_gnt_o  = d_req_i & (~f_req_i | (last_q == LAST_F));
        sel_addr = '0;
        if (f_gnt_o) begin
            sel_addr = f_addr_i;
        end else if (d_gnt_o) begin
            sel_addr = d_addr_i;
        end
        mem_a_o = {sel_addr[31:2], 2'b00};
    end

    // Error classification of the granted address. Out of range wins over
    // misaligned for the data value; either raises err.
    always_comb begin
        misaligned   = |sel_addr[1:0];
        out_of_range = |sel_addr[31:ADDR_WIDTH+2];
        resp_data    = out_of_range ? '0 : mem_rd_i;
        resp_err     = misaligned | out_of_range;
    end

    // Per-port response registers; only the granted port's data/err update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f_rvalid_o <= 1'b0;
            f_rdata_o  <= '0;
            f_err_o    <= 1'b0;
            d_rvalid_o <= 1'b0;
            d_rdata_o  <= '0;
            d_err_o    <= 1'b0;
        end else begin
            f_rvalid_o <= f_gnt_o;
            d_rvalid_o <= d_gnt_o;
            if (f_gnt_o) begin
                f_rdata_o <= resp_data;
                f_err_o   <= resp_err;
            end
            if (d_gnt_o) begin
                d_rdata_o <= resp_data;
                d_err_o   <= resp_err;
            end
        end
    end

endmodule

// File: tb/tb_ucsbece154a_imem_arbiter.sv
// Directed testbench for ucsbece154a_imem_arbiter with a 64-word
// instruction memory model. Inputs change on the falling edge; outputs are
// sampled 1 time unit later.
module tb_ucsbece154a_imem_arbiter;

    logic        clk;
    logic        reset_n;
    logic        f_req_i, d_req_i;
    logic [31:0] f_addr_i, d_addr_i;
    logic        f_gnt_o, d_gnt_o;
    logic        f_rvalid_o, d_rvalid_o;
    logic [31:0] f_rdata_o, d_rdata_o;
    logic        f_err_o, d_err_o;
    logic [31:0] mem_a_o;
    logic [31:0] mem_rd_i;

    logic [31:0] mem [64];

    int errors = 0;
    int checks = 0;

    ucsbece154a_imem_arbiter #(.NUM_WORDS(64)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .f_req_i    (f_req_i),
        .f_addr_i   (f_addr_i),
        .f_gnt_o    (f_gnt_o),
        .f_rvalid_o (f_rvalid_o),
        .f_rdata_o  (f_rdata_o),
        .f_err_o    (f_err_o),
        .d_req_i    (d_req_i),
        .d_addr_i   (d_addr_i),
        .d_gnt_o    (d_gnt_o),
        .d_rvalid_o (d_rvalid_o),
        .d_rdata_o  (d_rdata_o),
        .d_err_o    (d_err_o),
        .mem_a_o    (mem_a_o),
        .mem_rd_i   (mem_rd_i)
    );

    // Memory aliases on the low address bits, so an out-of-range address
    // returns nonzero data that the arbiter must suppress.
    assign mem_rd_i = mem[mem_a_o[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + i;
        mem[4] = 32'h0050_0113;

        reset_n  = 1'b0;
        f_req_i  = 1'b0;
        d_req_i  = 1'b0;
        f_addr_i = 32'h0;
        d_addr_i = 32'h0;

        // Reset: registered outputs 0, grant follows request combinationally.
        #1;
        chk1 ("rst_f_rvalid", f_rvalid_o, 1'b0);
        chk1 ("rst_d_rvalid", d_rvalid_o, 1'b0);
        chk32("rst_f_rdata",  f_rdata_o,  32'h0);
        chk32("rst_d_rdata",  d_rdata_o,  32'h0);
        chk1 ("rst_f_err",    f_err_o,    1'b0);
        chk1 ("rst_d_err",    d_err_o,    1'b0);
        chk32("rst_mem_a_idle", mem_a_o,  32'h0);
        d_req_i  = 1'b1;
        d_addr_i = 32'h8;
        #1;
        chk1 ("rst_d_gnt_follow", d_gnt_o, 1'b1);
        chk32("rst_mem_a_follow", mem_a_o, 32'h8);
        d_req_i  = 1'b0;
        d_addr_i = 32'h0;

        @(negedge clk);
        reset_n = 1'b1;

        // Single fetch of 0x10.
        @(negedge clk);
        f_req_i  = 1'b1;
        f_addr_i = 32'h10;
        #1;
        chk1 ("t1_f_gnt", f_gnt_o, 1'b1);
        chk1 ("t1_d_gnt", d_gnt_o, 1'b0);
        chk32("t1_mem_a", mem_a_o, 32'h10);
        @(negedge clk);
        f_req_i = 1'b0;
        #1;
        chk1 ("t1_f_rvalid", f_rvalid_o, 1'b1);
        chk32("t1_f_rdata",  f_rdata_o,  32'h0050_0113);
        chk1 ("t1_f_err",    f_err_o,    1'b0);
        chk1 ("t1_d_rvalid", d_rvalid_o, 1'b0);

        // Conflict from reset: grants alternate F, D, F, D, F, D.
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            f_req_i  = (i < 6);
            d_req_i  = (i < 6);
            f_addr_i = 32'h0;
            d_addr_i = 32'h4;
            #1;
            if (i < 6) begin
                chk1("t2_f_gnt", f_gnt_o, (i % 2) == 0);
                chk1("t2_d_gnt", d_gnt_o, (i % 2) == 1);
            end
            if (i > 0) begin
                chk1("t2_f_rvalid", f_rvalid_o, ((i - 1) % 2) == 0);
                chk1("t2_d_rvalid", d_rvalid_o, ((i - 1) % 2) == 1);
                if (((i - 1) % 2) == 0) chk32("t2_f_rdata", f_rdata_o, 32'hA000_0000);
                else                    chk32("t2_d_rdata", d_rdata_o, 32'hA000_0001);
            end
        end

        // Back-to-back fetch of words 0..3.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            f_req_i  = (i < 4);
            f_addr_i = 32'(4 * i);
            #1;
            if (i < 4) begin
                chk1 ("t3_f_gnt", f_gnt_o, 1'b1);
                chk32("t3_mem_a", mem_a_o, 32'(4 * i));
            end
            if (i > 0) begin
                chk1 ("t3_f_rvalid", f_rvalid_o, 1'b1);
                chk32("t3_f_rdata",  f_rdata_o,  32'hA000_0000 + 32'(i - 1));
            end
        end

        // Misaligned debug read 0x6: coerced word 1, err set.
        @(negedge clk);
        d_req_i  = 1'b1;
        d_addr_i = 32'h6;
        #1;
        chk1 ("t4_mis_d_gnt", d_gnt_o, 1'b1);
        chk32("t4_mis_mem_a", mem_a_o, 32'h4);
        @(negedge clk);
        d_req_i = 1'b0;
        #1;
        chk1 ("t4_mis_d_rvalid", d_rvalid_o, 1'b1);
        chk32("t4_mis_d_rdata",  d_rdata_o,  32'hA000_0001);
        chk1 ("t4_mis_d_err",    d_err_o,    1'b1);
        chk1 ("t4_mis_f_rvalid", f_rvalid_o, 1'b0);
        chk32("t4_mis_f_rdata",  f_rdata_o,  32'hA000_0003);
        chk1 ("t4_mis_f_err",    f_err_o,    1'b0);

        // Out-of-range debug read 0x100: data zeroed, err set.
        @(negedge clk);
        d_req_i  = 1'b1;
        d_addr_i = 32'h100;
        @(negedge clk);
        d_req_i = 1'b0;
        #1;
        chk1 ("t4_oor_d_rvalid", d_rvalid_o, 1'b1);
        chk32("t4_oor_d_rdata",  d_rdata_o,  32'h0);
        chk1 ("t4_oor_d_err",    d_err_o,    1'b1);
        chk32("t4_oor_f_rdata",  f_rdata_o,  32'hA000_0003);

        // Both conditions: 0x102.
        @(negedge clk);
        d_req_i  = 1'b1;
        d_addr_i = 32'h102;
        @(negedge clk);
        d_req_i = 1'b0;
        #1;
        chk32("t4_both_d_rdata", d_rdata_o, 32'h0);
        chk1 ("t4_both_d_err",   d_err_o,   1'b1);

        // Clean debug read of word 2, then hold while idle.
        @(negedge clk);
        d_req_i  = 1'b1;
        d_addr_i = 32'h8;
        @(negedge clk);
        d_req_i = 1'b0;
        #1;
        chk32("t6_d_rdata", d_rdata_o, 32'hA000_0002);
        chk1 ("t6_d_err",   d_err_o,   1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk32("t6_hold_d_rdata",  d_rdata_o,  32'hA000_0002);
            chk1 ("t6_hold_d_err",    d_err_o,    1'b0);
            chk1 ("t6_hold_d_rvalid", d_rvalid_o, 1'b0);
            chk1 ("t6_hold_f_gnt",    f_gnt_o,    1'b0);
            chk1 ("t6_hold_d_gnt",    d_gnt_o,    1'b0);
        end

        // Mid-operation reset: fetch accepted, reset drops before next edge.
        @(negedge clk);
        f_req_i  = 1'b1;
        f_addr_i = 32'hC;
        @(posedge clk);
        #2;
        f_req_i = 1'b0;
        reset_n = 1'b0;
        #1;
        chk1 ("t5_f_rvalid", f_rvalid_o, 1'b0);
        chk32("t5_f_rdata",  f_rdata_o,  32'h0);
        chk32("t5_d_rdata",  d_rdata_o,  32'h0);
        @(negedge clk);
        reset_n  = 1'b1;
        f_req_i  = 1'b1;
        d_req_i  = 1'b1;
        f_addr_i = 32'h0;
        d_addr_i = 32'h4;
        #1;
        chk1("t5_first_f_gnt", f_gnt_o, 1'b1);
        chk1("t5_first_d_gnt", d_gnt_o, 1'b0);
        @(negedge clk);
        #1;
        chk1("t5_second_d_gnt", d_gnt_o, 1'b1);
        chk1("t5_f_rvalid_after", f_rvalid_o, 1'b1);
        f_req_i = 1'b0;
        d_req_i = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
